// File: rtl/serial_tx8.sv
// Parallel-to-serial frame transmitter: start bit, 8 data bits LSB first,
// optional even-parity bit, stop bit; each bit held for CLKS_PER_BIT clocks.
module serial_tx8 #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       tx,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] cnt_r;
    logic [7:0] next_cnt_s;
    logic [2:0] idx_r;
    logic [2:0] next_idx_s;
    logic [7:0] shift_r;
    logic [7:0] next_shift_s;
    logic       parity_r;
    logic       next_parity_s;
    logic       tx_r;
    logic       next_tx_s;
    logic       done_r;
    logic       next_done_s;
    logic       ready_r;
    logic       busy_r;
    logic       bit_end_s;

    function automatic logic even_parity(input logic [7:0] word);
        return ^word;
    endfunction

    assign bit_end_s = (cnt_r == CNT_MAX);
    assign ready     = ready_r;
    assign busy      = busy_r;
    assign tx        = tx_r;
    assign done      = done_r;

    // Next-state, counters, shift register and the value tx takes after the edge.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        next_idx_s    = idx_r;
        next_shift_s  = shift_r;
        next_parity_s = parity_r;
        next_tx_s     = 1'b1;
        next_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (load) begin
                    next_state_s  = START;
                    next_shift_s  = din;
                    next_parity_s = even_parity(din);
                    next_cnt_s    = 8'd0;
                    next_idx_s    = 3'd0;
                    next_tx_s     = 1'b0;
                end else begin
                    next_tx_s = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    next_state_s = DATA;
                    next_cnt_s   = 8'd0;
                    next_tx_s    = shift_r[0];
                end else begin
                    next_cnt_s = cnt_r + 8'd1;
                    next_tx_s  = 1'b0;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    next_cnt_s   = 8'd0;
                    next_shift_s = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        next_idx_s = 3'd0;
                        if (PARITY_EN != 0) begin
                            next_state_s = PARITY;
                            next_tx_s    = parity_r;
                        end else begin
                            next_state_s = STOP;
                            next_tx_s    = 1'b1;
                        end
                    end else begin
                        next_idx_s = idx_r + 3'd1;
                        next_tx_s  = shift_r[1];
                    end
                end else begin
                    next_cnt_s = cnt_r + 8'd1;
                    next_tx_s  = shift_r[0];
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    next_state_s = STOP;
                    next_cnt_s   = 8'd0;
                    next_tx_s    = 1'b1;
                end else begin
                    next_cnt_s = cnt_r + 8'd1;
                    next_tx_s  = parity_r;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    next_state_s = IDLE;
                    next_cnt_s   = 8'd0;
                    next_done_s  = 1'b1;
                end else begin
                    next_cnt_s = cnt_r + 8'd1;
                end
                next_tx_s = 1'b1;
            end
            default: begin
                next_state_s = IDLE;
                next_cnt_s   = 8'd0;
                next_idx_s   = 3'd0;
                next_tx_s    = 1'b1;
            end
        endcase
    end

    // State and output registers; ready/busy are decoded from the next state
    // so they stay aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 8'd0;
            idx_r    <= 3'd0;
            shift_r  <= 8'd0;
            parity_r <= 1'b0;
            tx_r     <= 1'b1;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= next_cnt_s;
            idx_r    <= next_idx_s;
            shift_r  <= next_shift_s;
            parity_r <= next_parity_s;
            tx_r     <= next_tx_s;
            done_r   <= next_done_s;
            ready_r  <= (next_state_s == IDLE);
            busy_r   <= (next_state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_serial_tx8.sv
// Self-checking bench for serial_tx8: a default instance and a
// PARITY_EN=0 / CLKS_PER_BIT=1 instance, compared against a frame model.
module tb_serial_tx8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din1, din2;
    logic       load1, load2;
    logic       ready1, busy1, tx1, done1;
    logic       ready2, busy2, tx2, done2;

    int n_cmp = 0;
    int n_err = 0;
    int dcnt1 = 0;
    int dcnt2 = 0;

    serial_tx8 dut1 (
        .clk(clk), .rst(rst), .din(din1), .load(load1),
        .ready(ready1), .busy(busy1), .tx(tx1), .done(done1)
    );

    serial_tx8 #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .load(load2),
        .ready(ready2), .busy(busy2), .tx(tx2), .done(done2)
    );

    always #5 clk = ~clk;

    // Count done pulses, one per high cycle.
    always @(negedge clk) begin
        if (done1 === 1'b1) dcnt1++;
        if (done2 === 1'b1) dcnt2++;
    end

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {tx2, busy2, ready2, done2} : {tx1, busy1, ready1, done1};
    endfunction

    task automatic drive(input bit sel, input logic [7:0] d, input logic l);
        if (sel) begin
            din2  = d;
            load2 = l;
        end else begin
            din1  = d;
            load1 = l;
        end
    endtask

    // Call at a negedge with the selected DUT idle; returns at the negedge of the done cycle.
    task automatic run_frame(input bit sel, input logic [7:0] w, input logic [7:0] mid_din,
                             input bit keep_load, input int pulse_k);
        bit         expb[$];
        int         c;
        int         ones;
        logic [3:0] o;
        c = sel ? 1 : 4;
        for (int r = 0; r < c; r++) expb.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < c; r++) expb.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (!sel) for (int r = 0; r < c; r++) expb.push_back(ones % 2 == 1);
        for (int r = 0; r < c; r++) expb.push_back(1'b1);

        drive(sel, w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(sel, mid_din, keep_load);
        for (int k = 0; k < expb.size(); k++) begin
            o = obs(sel);
            n_cmp++;
            if (o !== {expb[k], 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL frame sel=%0d word=%h cycle=%0d tx/busy/ready/done got %b want %b",
                         sel, w, k, o, {expb[k], 3'b100});
            end
            if (k == pulse_k) drive(sel, mid_din, 1'b1);
            else if (k == pulse_k + 1) drive(sel, mid_din, keep_load);
            @(negedge clk);
        end
        o = obs(sel);
        n_cmp++;
        if (o !== 4'b1011) begin
            n_err++;
            $display("FAIL frame_done sel=%0d word=%h got %b want 1011", sel, w, o);
        end
    endtask

    task automatic check_idle(input bit sel, input string name);
        logic [3:0] o;
        o = obs(sel);
        n_cmp++;
        if (o !== 4'b1010) begin
            n_err++;
            $display("FAIL %s sel=%0d tx/busy/ready/done got %b want 1010", name, sel, o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load1 = 1'b0; load2 = 1'b0; din1 = 8'h00; din2 = 8'h00;
        #1;
        check_idle(1'b0, "reset_async");
        check_idle(1'b1, "reset_async");
        repeat (3) @(negedge clk);
        check_idle(1'b0, "reset_held");
        check_idle(1'b1, "reset_held");
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        run_frame(1'b0, 8'b10101010, 8'h00, 1'b0, -1);
        @(negedge clk); check_idle(1'b0, "after_aa");
        run_frame(1'b0, 8'b00000111, 8'hFF, 1'b0, -1);
        @(negedge clk); check_idle(1'b0, "after_07");
        run_frame(1'b1, 8'b11110000, 8'h0F, 1'b0, -1);
        @(negedge clk); check_idle(1'b1, "after_f0");
    endtask

    task automatic test_random();
        bit sel;
        for (int i = 0; i < 12; i++) begin
            sel = bit'($urandom_range(0, 1));
            run_frame(sel, 8'($urandom), 8'($urandom), 1'b0, -1);
            @(negedge clk); check_idle(sel, "after_random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_load_ignored();
        int d1, d2;
        d1 = dcnt1;
        run_frame(1'b0, 8'($urandom), 8'($urandom), 1'b0, int'($urandom_range(0, 40)));
        @(negedge clk); check_idle(1'b0, "ignored_idle");
        n_cmp++;
        if (dcnt1 - d1 != 1) begin
            n_err++;
            $display("FAIL load_ignored_done_count sel=0 got %0d want 1", dcnt1 - d1);
        end
        d2 = dcnt2;
        run_frame(1'b1, 8'($urandom), 8'($urandom), 1'b0, int'($urandom_range(0, 7)));
        @(negedge clk); check_idle(1'b1, "ignored_idle");
        n_cmp++;
        if (dcnt2 - d2 != 1) begin
            n_err++;
            $display("FAIL load_ignored_done_count sel=1 got %0d want 1", dcnt2 - d2);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        d1 = dcnt1;
        run_frame(1'b0, 8'h55, 8'h0F, 1'b1, -1);
        run_frame(1'b0, 8'h0F, 8'h0F, 1'b0, -1);
        @(negedge clk); check_idle(1'b0, "b2b_idle");
        n_cmp++;
        if (dcnt1 - d1 != 2) begin
            n_err++;
            $display("FAIL b2b_done_count sel=0 got %0d want 2", dcnt1 - d1);
        end
        d2 = dcnt2;
        for (int i = 0; i < 3; i++) run_frame(1'b1, 8'($urandom), 8'($urandom), 1'b1, -1);
        run_frame(1'b1, 8'($urandom), 8'($urandom), 1'b0, -1);
        @(negedge clk); check_idle(1'b1, "b2b_idle");
        n_cmp++;
        if (dcnt2 - d2 != 4) begin
            n_err++;
            $display("FAIL b2b_done_count sel=1 got %0d want 4", dcnt2 - d2);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] w;
        int         d1;
        w = 8'($urandom);
        drive(1'b0, w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'($urandom), 1'b0);
        repeat (17) @(negedge clk);
        n_cmp++;
        if (tx1 !== w[3]) begin
            n_err++;
            $display("FAIL mid_reset_data_bit3 got %b want %b", tx1, w[3]);
        end
        d1 = dcnt1;
        rst = 1'b1;
        #1;
        check_idle(1'b0, "mid_reset_async");
        @(negedge clk);
        check_idle(1'b0, "mid_reset_held");
        rst = 1'b0;
        run_frame(1'b0, 8'($urandom), 8'($urandom), 1'b0, -1);
        @(negedge clk); check_idle(1'b0, "post_reset_idle");
        n_cmp++;
        if (dcnt1 - d1 != 1) begin
            n_err++;
            $display("FAIL mid_reset_done_count got %0d want 1", dcnt1 - d1);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_load_ignored();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tx8.md
SERIAL_TX8 -- requirements
Module: serial_tx8

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held on tx (legal range 1..255).
REQ-002 Parameter PARITY_EN, default 1, 1 = insert an even-parity bit after the data bits, 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  8  parallel word, normally driven by the 8-bit register output Q.
REQ-006 load  input  1  request to transmit din; sampled on the rising edge of clk.
REQ-007 ready  output  1  high when a load will be accepted.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, and SHALL encode them in a 3-bit state register.
REQ-012 ready SHALL equal (state==IDLE), and busy SHALL equal !ready.
REQ-013 A load SHALL be accepted only on an edge where load=1 and state=IDLE; on acceptance, din SHALL be captured into an internal shift register, and the state SHALL become START on the same edge.
REQ-014 While state≠IDLE, load SHALL be ignored, and din changes SHALL NOT affect the frame in progress.
REQ-015 A bit counter SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles.
REQ-016 tx SHALL be registered, with the following values: 1 in IDLE, 0 in START, shift-register bit 0 in DATA, the parity bit in PARITY, and 1 in STOP.
REQ-017 DATA SHALL send 8 bits LSB first, shifting right once per bit period; a 3-bit index SHALL count 0..7, and DATA SHALL exit after index 7 completes.
REQ-018 The parity bit SHALL be the XOR of the 8 captured bits, so that the data plus parity bits contain an even number of ones; it SHALL be computed from the captured word, not from din.
REQ-019 The transition after DATA SHALL be to PARITY when PARITY_EN=1 and directly to STOP when PARITY_EN=0.
REQ-020 After STOP completes, the state SHALL return to IDLE, and done SHALL be 1 for exactly the first IDLE cycle.
REQ-021 Frame length from acceptance edge to the done cycle SHALL be CLKS_PER_BIT×(10+PARITY_EN) cycles: 44 cycles at the defaults.
REQ-022 A load=1 during the done cycle SHALL be accepted, giving back-to-back frames with no idle bit period between them.
REQ-023 A load held continuously high SHALL start a new frame on every IDLE cycle; no edge detection SHALL be performed.
REQ-024 All counters SHALL wrap only under FSM control; no counter SHALL overflow its width for legal CLKS_PER_BIT values.

Reset
REQ-025 While rst=1, independent of clk, the outputs SHALL be: state=IDLE, tx=1, ready=1, busy=0, done=0, and the shift register, bit counter and index SHALL all be 0.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately, forcing tx=1 with no done pulse; after release, the block SHALL be in IDLE and accept the next load.
REQ-027 The first load SHALL be accepted on the first rising edge after rst deasserts with load=1.

Verification
REQ-028 Defaults, din=8'b10101010, one-cycle load → tx per 4-cycle bit: 0, 0,1,0,1,0,1,0,1, parity 0, stop 1; done at cycle 44; busy high for cycles 1..44 after the acceptance edge, inclusive of 1 and exclusive of 44.
REQ-029 Defaults, din=8'b00000111 → data bits 1,1,1,0,0,0,0,0, parity bit 1.
REQ-030 PARITY_EN=0, CLKS_PER_BIT=1, din=8'b11110000 → tx: 0,0,0,0,0,1,1,1,1,1; done 10 cycles after acceptance.
REQ-031 load held high with din=8'h55 then din=8'h0F → second frame starts in the done cycle of the first; din change mid-frame does not alter the first frame's bits.
REQ-032 rst pulsed during DATA bit 3 → tx=1 and ready=1 immediately, done stays 0; a new load after release produces a complete correct frame.
REQ-033 load pulsed while busy=1 → ignored: exactly one frame and one done pulse.
